// File: rtl/mundo_seq.sv
// World-progression sequencer: synchronises per-world Set flags, requires a steady hold to advance,
// drives a 7-segment world digit and Win. Optional wrong-world error counter via MUNDO_SEQ_ERR_EN.
module mundo_seq #(
  parameter int NUM_MUNDOS  = 4,
  parameter int HOLD_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Op,
  input  logic                  Clr,
  input  logic [NUM_MUNDOS-1:0] Set,
  output logic [1:0]            Mundo,
  output logic                  Adv,
  output logic                  Win,
  output logic [6:0]            Seg,
  output logic [3:0]            Err
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {PLAY, HOLD, ADV, REL, WIN} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [1:0]            mundo_reg, mundo_next;
  logic [6:0]            seg_reg, seg_next;
  logic [NUM_MUNDOS-1:0] s_meta_reg, s_reg;
  logic [3:0]            s_ext;
  logic                  cur;
  logic                  any_s;
  logic                  mundo_last;

  // Set is asynchronous to clk: two flops per bit before anything looks at it
  generate
    for (genvar gi = 0; gi < NUM_MUNDOS; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_meta_reg[gi] <= 1'b0;
          s_reg[gi]      <= 1'b0;
        end else begin
          s_meta_reg[gi] <= Set[gi];
          s_reg[gi]      <= s_meta_reg[gi];
        end
      end
    end
  endgenerate

  assign s_ext      = 4'(s_reg);
  assign cur        = s_ext[mundo_reg];
  assign any_s      = |s_reg;
  assign mundo_last = (mundo_reg == 2'(NUM_MUNDOS - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mundo_next = mundo_reg;
    if (Clr) begin
      state_next = PLAY;
      cnt_next   = '0;
      mundo_next = 2'd0;
    end else begin
      case (state_reg)
        PLAY: begin
          cnt_next = '0;
          if (cur && !Op) begin
            state_next = HOLD;
            cnt_next   = CW'(1);
          end
        end
        HOLD: begin
          if (Op || !cur) begin
            state_next = PLAY;
            cnt_next   = '0;
          end else if (cnt_reg == CW'(HOLD_CYCLES)) begin
            state_next = ADV;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        ADV: begin
          if (mundo_last) begin
            state_next = WIN;
          end else begin
            mundo_next = mundo_reg + 2'd1;
            state_next = REL;
          end
        end
        // Wait for every flag to drop so a pattern held across the change cannot arm the next world
        REL: begin
          if (!any_s) state_next = PLAY;
        end
        WIN:     state_next = WIN;
        default: state_next = PLAY;
      endcase
    end
  end

  always_comb begin
    seg_next = 7'h79;
    if (state_reg == WIN) begin
      seg_next = 7'h3F;
    end else begin
      case (mundo_reg)
        2'd0: seg_next = 7'h79;
        2'd1: seg_next = 7'h24;
        2'd2: seg_next = 7'h30;
        2'd3: seg_next = 7'h19;
        default: seg_next = 7'h79;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= PLAY;
      cnt_reg   <= '0;
      mundo_reg <= 2'd0;
      seg_reg   <= 7'h79;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mundo_reg <= mundo_next;
      seg_reg   <= seg_next;
    end
  end

  assign Mundo = mundo_reg;
  assign Adv   = (state_reg == ADV);
  assign Win   = (state_reg == WIN);
  assign Seg   = seg_reg;

`ifdef MUNDO_SEQ_ERR_EN
  logic [NUM_MUNDOS-1:0] s_prev_reg;
  logic [3:0]            err_reg;
  logic [3:0]            rise;
  logic                  err_hit;

  // Rising edges on any non-current world; several in one cycle count once
  assign rise    = 4'(s_reg & ~s_prev_reg) & ~(4'b0001 << mundo_reg);
  assign err_hit = (|rise) && ((state_reg == PLAY) || (state_reg == HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev_reg <= '0;
      err_reg    <= 4'h0;
    end else begin
      s_prev_reg <= s_reg;
      if (Clr)
        err_reg <= 4'h0;
      else if (err_hit && (err_reg != 4'hF))
        err_reg <= err_reg + 4'h1;
    end
  end

  assign Err = err_reg;
`else
  assign Err = 4'h0;
`endif

endmodule
